// File: rtl/neuron_pkg.sv
// Shared types and default widths for the synapse learning controller.
// Optional post-spike counter is enabled by SYN_CTRL_SPIKE_CNT_EN.
package neuron_pkg;

  localparam int SYN_EPOCH_W = 8;
  localparam int SYN_STEP_W  = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TRAIN,
    EPOCH_END,
    STORE,
    DONE
  } syn_ctrl_state_t;

endpackage

// File: rtl/synapse_learning_ctrl_if.sv
// Control, config and spike bundle for synapse_learning_ctrl.
// post_cnt exists only when SYN_CTRL_SPIKE_CNT_EN is defined.
interface synapse_learning_ctrl_if
  import neuron_pkg::*;
#(
  parameter int NUM_SYN = 8,
  parameter int EPOCH_W = SYN_EPOCH_W,
  parameter int STEP_W  = SYN_STEP_W
);

  logic               start;
  logic               abort;
  logic [EPOCH_W-1:0] cfg_epochs;
  logic [STEP_W-1:0]  cfg_steps;
  logic [NUM_SYN-1:0] pre_spike_in;
  logic               post_spike_in;
  logic [NUM_SYN-1:0] pre_spike_out;
  logic               post_spike_out;
  logic               learning_enable;
  logic               store_final;
  logic               epoch_done;
  logic [EPOCH_W-1:0] epoch_cnt;
  logic               busy;
  logic               done;
`ifdef SYN_CTRL_SPIKE_CNT_EN
  logic [STEP_W-1:0]  post_cnt;
`endif

  modport master (
    output start,
    output abort,
    output cfg_epochs,
    output cfg_steps,
    output pre_spike_in,
    output post_spike_in,
    input  pre_spike_out,
    input  post_spike_out,
    input  learning_enable,
    input  store_final,
    input  epoch_done,
    input  epoch_cnt,
    input  busy,
    input  done
`ifdef SYN_CTRL_SPIKE_CNT_EN
    ,
    input  post_cnt
`endif
  );

  modport slave (
    input  start,
    input  abort,
    input  cfg_epochs,
    input  cfg_steps,
    input  pre_spike_in,
    input  post_spike_in,
    output pre_spike_out,
    output post_spike_out,
    output learning_enable,
    output store_final,
    output epoch_done,
    output epoch_cnt,
    output busy,
    output done
`ifdef SYN_CTRL_SPIKE_CNT_EN
    ,
    output post_cnt
`endif
  );

endinterface

// File: rtl/synapse_learning_ctrl_epoch_counter.sv
// Timestep and epoch counters with clear/enable and terminal flags.
// Epoch count saturates at all-ones.
module syn_epoch_counter #(
  parameter int EPOCH_W = 8,
  parameter int STEP_W  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step_clr,
  input  logic               step_en,
  input  logic [STEP_W-1:0]  steps,
  input  logic               epoch_clr,
  input  logic               epoch_en,
  input  logic [EPOCH_W-1:0] epochs,
  output logic               step_last,
  output logic [EPOCH_W-1:0] epoch_cnt,
  output logic               epoch_last
);

  localparam int EW1 = EPOCH_W + 1;

  logic [STEP_W-1:0] step_cnt;
  logic [EW1-1:0]    epoch_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (step_clr) begin
      step_cnt <= '0;
    end else if (step_en) begin
      step_cnt <= step_cnt + STEP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epoch_cnt <= '0;
    end else if (epoch_clr) begin
      epoch_cnt <= '0;
    end else if (epoch_en && epoch_cnt != '1) begin
      epoch_cnt <= epoch_cnt + EPOCH_W'(1);
    end
  end

  // widened so the +1 never wraps onto a small cfg value
  assign epoch_nxt  = EW1'(epoch_cnt) + EW1'(1);
  assign epoch_last = epoch_nxt == EW1'(epochs);
  assign step_last  = step_cnt == steps - STEP_W'(1);

endmodule

// File: rtl/synapse_learning_ctrl.sv
// Training sequencer for a synapse bank: FSM, spike gating, registered outputs.
// Define SYN_CTRL_SPIKE_CNT_EN to add the per-epoch post_cnt output.
module synapse_learning_ctrl
  import neuron_pkg::*;
#(
  parameter int NUM_SYN   = 8,
  parameter int EPOCH_W   = SYN_EPOCH_W,
  parameter int STEP_W    = SYN_STEP_W,
  parameter int STORE_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  synapse_learning_ctrl_if.slave  bus
);

  localparam int SC_W = (STORE_CYC > 1) ? $clog2(STORE_CYC) : 1;

  syn_ctrl_state_t    state;
  syn_ctrl_state_t    nxt;
  logic [EPOCH_W-1:0] ep_q;
  logic [STEP_W-1:0]  st_q;
  logic [SC_W-1:0]    sc_cnt;
  logic               accept;
  logic               step_last;
  logic               epoch_last;
  logic               store_last;
  logic [EPOCH_W-1:0] epoch_cnt;
  logic [NUM_SYN-1:0] pre_q;
  logic               post_q;
  logic               le_q;
  logic               sf_q;
  logic               ed_q;
  logic               busy_q;
  logic               done_q;

  assign accept     = (state == IDLE) && bus.start && !bus.abort;
  assign store_last = sc_cnt == SC_W'(STORE_CYC - 1);

  always_comb begin
    nxt = state;
    if (bus.abort) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:      if (bus.start) nxt = LOAD;
        LOAD:      nxt = (ep_q == '0) ? STORE : TRAIN;
        TRAIN:     if (step_last) nxt = EPOCH_END;
        EPOCH_END: nxt = epoch_last ? STORE : TRAIN;
        STORE:     if (store_last) nxt = DONE;
        DONE:      nxt = IDLE;
        default:   nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // zero steps would never terminate an epoch, so it runs as one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ep_q <= '0;
      st_q <= '0;
    end else if (accept) begin
      ep_q <= bus.cfg_epochs;
      st_q <= (bus.cfg_steps == '0) ? STEP_W'(1) : bus.cfg_steps;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_cnt <= '0;
    end else if (state != STORE) begin
      sc_cnt <= '0;
    end else begin
      sc_cnt <= sc_cnt + SC_W'(1);
    end
  end

  syn_epoch_counter #(
    .EPOCH_W (EPOCH_W),
    .STEP_W  (STEP_W)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_clr   (state != TRAIN),
    .step_en    (state == TRAIN),
    .steps      (st_q),
    .epoch_clr  (accept),
    .epoch_en   ((state == EPOCH_END) && !bus.abort),
    .epochs     (ep_q),
    .step_last  (step_last),
    .epoch_cnt  (epoch_cnt),
    .epoch_last (epoch_last)
  );

  // decoded from nxt so each flag lines up with the state it names
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      le_q   <= 1'b0;
      sf_q   <= 1'b0;
      ed_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pre_q  <= '0;
      post_q <= 1'b0;
    end else begin
      le_q   <= nxt == TRAIN;
      sf_q   <= nxt == STORE;
      ed_q   <= nxt == EPOCH_END;
      busy_q <= nxt != IDLE;
      done_q <= nxt == DONE;
      pre_q  <= (nxt == TRAIN) ? bus.pre_spike_in : '0;
      post_q <= (nxt == TRAIN) && bus.post_spike_in;
    end
  end

`ifdef SYN_CTRL_SPIKE_CNT_EN
  logic [STEP_W-1:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else if (nxt == TRAIN && state != TRAIN) begin
      pc_q <= '0;
    end else if (state == TRAIN && post_q && pc_q != '1) begin
      pc_q <= pc_q + STEP_W'(1);
    end
  end

  assign bus.post_cnt = pc_q;
`endif

  assign bus.pre_spike_out   = pre_q;
  assign bus.post_spike_out  = post_q;
  assign bus.learning_enable = le_q;
  assign bus.store_final     = sf_q;
  assign bus.epoch_done      = ed_q;
  assign bus.epoch_cnt       = epoch_cnt;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;

endmodule

// File: tb/tb_synapse_learning_ctrl.sv
// Directed bench for synapse_learning_ctrl.
// Post-counter steps run only with SYN_CTRL_SPIKE_CNT_EN defined.
module tb_synapse_learning_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   n_le, n_ed, n_st, n_done, n_pre, n_post, n_bad, cyc;

  synapse_learning_ctrl_if #(
    .NUM_SYN (8),
    .EPOCH_W (8),
    .STEP_W  (10)
  ) bus ();

  synapse_learning_ctrl #(
    .NUM_SYN   (8),
    .EPOCH_W   (8),
    .STEP_W    (10),
    .STORE_CYC (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_to_done(input int max);
    n_le = 0; n_ed = 0; n_st = 0; n_done = 0;
    n_pre = 0; n_post = 0; n_bad = 0; cyc = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      bus.start = 1'b0;
      if (bus.learning_enable) n_le++;
      if (bus.epoch_done) n_ed++;
      if (bus.store_final) n_st++;
      if (bus.pre_spike_out == 8'hA5) n_pre++;
      if (bus.post_spike_out) n_post++;
      if (bus.pre_spike_out !==
          (bus.learning_enable ? bus.pre_spike_in : 8'h00))
        n_bad++;
      if (bus.post_spike_out !==
          (bus.learning_enable & bus.post_spike_in))
        n_bad++;
      if (bus.done) begin
        n_done++;
        cyc = i + 1;
        break;
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_epochs = '0;
    bus.cfg_steps = '0;
    bus.pre_spike_in = '0;
    bus.post_spike_in = 1'b0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_le", bus.learning_enable, 0);
    chk("rst_store", bus.store_final, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ecnt", bus.epoch_cnt, 0);
    chk("rst_pre", bus.pre_spike_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 2 epochs x 3 steps
    bus.cfg_epochs = 8'd2;
    bus.cfg_steps = 10'd3;
    bus.start = 1'b1;
    run_to_done(40);
    chk("t1_done", n_done, 1);
    chk("t1_cyc", cyc, 12);
    chk("t1_le", n_le, 6);
    chk("t1_ed", n_ed, 2);
    chk("t1_store", n_st, 2);
    chk("t1_ecnt", bus.epoch_cnt, 2);
    tick();
    chk("t1_idle_busy", bus.busy, 0);
    chk("t1_idle_done", bus.done, 0);
    chk("t1_hold_ecnt", bus.epoch_cnt, 2);

    // zero epochs: straight to store
    bus.cfg_epochs = 8'd0;
    bus.cfg_steps = 10'd5;
    bus.start = 1'b1;
    run_to_done(40);
    chk("t2_done", n_done, 1);
    chk("t2_cyc", cyc, 4);
    chk("t2_le", n_le, 0);
    chk("t2_ed", n_ed, 0);
    chk("t2_store", n_st, 2);
    chk("t2_ecnt", bus.epoch_cnt, 0);
    tick();

    // spikes only pass while training
    bus.pre_spike_in = 8'hA5;
    bus.post_spike_in = 1'b1;
    bus.cfg_epochs = 8'd1;
    bus.cfg_steps = 10'd2;
    bus.start = 1'b1;
    run_to_done(40);
    chk("t3_cyc", cyc, 7);
    chk("t3_le", n_le, 2);
    chk("t3_pre_hi", n_pre, 2);
    chk("t3_post_hi", n_post, 2);
    chk("t3_gate_bad", n_bad, 0);
    chk("t3_ecnt", bus.epoch_cnt, 1);
    tick();
    chk("t3_idle_pre", bus.pre_spike_out, 0);
    chk("t3_idle_post", bus.post_spike_out, 0);
    bus.pre_spike_in = '0;
    bus.post_spike_in = 1'b0;

    // abort in the 2nd train cycle
    bus.cfg_epochs = 8'd2;
    bus.cfg_steps = 10'd4;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t4_load_busy", bus.busy, 1);
    chk("t4_load_le", bus.learning_enable, 0);
    tick();
    chk("t4_tr1_le", bus.learning_enable, 1);
    tick();
    chk("t4_tr2_le", bus.learning_enable, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t4_ab_busy", bus.busy, 0);
    chk("t4_ab_le", bus.learning_enable, 0);
    n_st = 0;
    n_done = 0;
    n_le = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.store_final) n_st++;
      if (bus.done) n_done++;
      if (bus.busy) n_le++;
      tick();
    end
    chk("t4_no_store", n_st, 0);
    chk("t4_no_done", n_done, 0);
    chk("t4_stay_idle", n_le, 0);

    // start during train is ignored; reset in store
    bus.cfg_epochs = 8'd1;
    bus.cfg_steps = 10'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.start = 1'b1;
    bus.cfg_epochs = 8'd5;
    bus.cfg_steps = 10'd1;
    tick();
    bus.start = 1'b0;
    chk("t5_tr3_le", bus.learning_enable, 1);
    tick();
    chk("t5_ed", bus.epoch_done, 1);
    tick();
    chk("t5_store", bus.store_final, 1);
    chk("t5_ecnt", bus.epoch_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_store", bus.store_final, 0);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_ecnt", bus.epoch_cnt, 0);
    chk("t5_rst_done", bus.done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_post_busy", bus.busy, 0);
    chk("t5_post_done", bus.done, 0);

`ifdef SYN_CTRL_SPIKE_CNT_EN
    bus.cfg_epochs = 8'd2;
    bus.cfg_steps = 10'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.post_spike_in = 1'b1;
    tick();
    chk("t6_post_t1", bus.post_spike_out, 1);
    bus.post_spike_in = 1'b0;
    tick();
    bus.post_spike_in = 1'b1;
    tick();
    bus.post_spike_in = 1'b0;
    tick();
    chk("t6_ed", bus.epoch_done, 1);
    chk("t6_pcnt", bus.post_cnt, 2);
    tick();
    chk("t6_le2", bus.learning_enable, 1);
    chk("t6_pcnt_clr", bus.post_cnt, 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t6_ab_busy", bus.busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
